// File: rtl/sha_pkg.sv
// Shared types and constants for the SHA-256 memory responder and its RAM.
package sha_pkg;

  localparam int WORD_W       = 32;
  localparam int DIGEST_WORDS = 8;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_START,
    ST_WAIT_BUSY,
    ST_WAIT_DONE,
    ST_DRAIN_RD,
    ST_DRAIN_HOLD
  } state_e;

  // SHA-256 initial hash values, h[0] in the most significant word.
  localparam logic [DIGEST_WORDS*WORD_W-1:0] SHA256_IV = {
    32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
    32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
  };

  function automatic logic [WORD_W-1:0] sha256_iv_word(input int unsigned i);
    return SHA256_IV[(DIGEST_WORDS-1-i)*WORD_W +: WORD_W];
  endfunction

endpackage

// File: rtl/sha_word_ram.sv
// DEPTH x 32 word array: one synchronous read port (read-first), one write port.
module sha_word_ram
  import sha_pkg::*;
#(
  parameter int DEPTH = 64,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [WORD_W-1:0] wdata,
  input  logic              re,
  input  logic [AW-1:0]     raddr,
  output logic [WORD_W-1:0] rdata
);

  logic [WORD_W-1:0] mem [DEPTH];
  logic [WORD_W-1:0] rdata_q;

  // Contents are deliberately not reset so a job can be retried after reset.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata_q <= mem[raddr];
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/sha_mem_responder.sv
// Memory-side responder for the SHA-256 core: loads the message, starts the
// core, serves its word bus and streams the 8-word digest back to the host.
module sha_mem_responder
  import sha_pkg::*;
#(
  parameter int          NUM_OF_WORDS   = 20,
  parameter int          DEPTH          = 64,
  parameter logic [15:0] BASE_ADDR      = 16'h0000,
  parameter logic [15:0] MSG_ADDR       = 16'h0000,
  parameter logic [15:0] OUT_ADDR       = 16'h0020,
  parameter int          TIMEOUT_CYCLES = 4096
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cmd_go,
  output logic              busy,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WORD_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [WORD_W-1:0] out_data,
  output logic              out_last,
  output logic              sha_start,
  input  logic              sha_done,
  output logic [15:0]       message_addr,
  output logic [15:0]       output_addr,
  input  logic [15:0]       mem_addr,
  input  logic              mem_we,
  input  logic [WORD_W-1:0] mem_write_data,
  output logic [WORD_W-1:0] mem_read_data,
  output logic              err_oob,
  output logic              err_timeout
);

  localparam int          AW      = $clog2(DEPTH);
  localparam int          LCNT_W  = $clog2(NUM_OF_WORDS + 1);
  localparam int          DCNT_W  = $clog2(DIGEST_WORDS);
  localparam int          TCNT_W  = $clog2(TIMEOUT_CYCLES);
  localparam logic [15:0] MSG_IDX = MSG_ADDR - BASE_ADDR;
  localparam logic [15:0] OUT_IDX = OUT_ADDR - BASE_ADDR;

  if (int'(MSG_IDX) + NUM_OF_WORDS > DEPTH) begin : g_msg_region_check
    $error("message region does not fit in the word array");
  end
  if (int'(OUT_IDX) + DIGEST_WORDS > DEPTH) begin : g_out_region_check
    $error("digest region does not fit in the word array");
  end

  state_e              state_q, state_d;
  logic [LCNT_W-1:0]   lcnt_q, lcnt_d;
  logic [DCNT_W-1:0]   dcnt_q, dcnt_d;
  logic [TCNT_W-1:0]   tcnt_q, tcnt_d;
  logic                err_oob_q, err_oob_d;
  logic                err_timeout_q, err_timeout_d;
  logic                core_rd_q, core_rd_d;
  logic                rd_oob_q, rd_oob_d;
  logic [WORD_W-1:0]   rd_hold_q, rd_hold_d;

  logic [15:0]         core_idx;
  logic                core_in_range;
  logic                core_phase;
  logic                ram_we, ram_re;
  logic [AW-1:0]       ram_waddr, ram_raddr;
  logic [WORD_W-1:0]   ram_wdata, ram_rdata;

  assign core_idx      = mem_addr - BASE_ADDR;
  assign core_in_range = core_idx < 16'(DEPTH);
  assign core_phase    = (state_q == ST_WAIT_BUSY) || (state_q == ST_WAIT_DONE);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      lcnt_q        <= '0;
      dcnt_q        <= '0;
      tcnt_q        <= '0;
      err_oob_q     <= 1'b0;
      err_timeout_q <= 1'b0;
      core_rd_q     <= 1'b0;
      rd_oob_q      <= 1'b0;
      rd_hold_q     <= '0;
    end else begin
      state_q       <= state_d;
      lcnt_q        <= lcnt_d;
      dcnt_q        <= dcnt_d;
      tcnt_q        <= tcnt_d;
      err_oob_q     <= err_oob_d;
      err_timeout_q <= err_timeout_d;
      core_rd_q     <= core_rd_d;
      rd_oob_q      <= rd_oob_d;
      rd_hold_q     <= rd_hold_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    lcnt_d        = lcnt_q;
    dcnt_d        = dcnt_q;
    tcnt_d        = tcnt_q;
    err_oob_d     = err_oob_q;
    err_timeout_d = err_timeout_q;
    case (state_q)
      ST_IDLE: begin
        if (cmd_go) begin
          err_oob_d     = 1'b0;
          err_timeout_d = 1'b0;
          lcnt_d        = '0;
          state_d       = ST_LOAD;
        end
      end
      ST_LOAD: begin
        if (in_valid) begin
          lcnt_d = lcnt_q + 1'b1;
          if (lcnt_q == LCNT_W'(NUM_OF_WORDS - 1)) state_d = ST_START;
        end
      end
      ST_START: state_d = ST_WAIT_BUSY;
      // done idles high, so only a sampled low proves the core has started
      ST_WAIT_BUSY: begin
        if (!sha_done) begin
          tcnt_d  = '0;
          state_d = ST_WAIT_DONE;
        end
      end
      ST_WAIT_DONE: begin
        tcnt_d = tcnt_q + 1'b1;
        if (sha_done) begin
          dcnt_d  = '0;
          state_d = ST_DRAIN_RD;
        end else if (tcnt_q == TCNT_W'(TIMEOUT_CYCLES - 1)) begin
          err_timeout_d = 1'b1;
          state_d       = ST_IDLE;
        end
      end
      ST_DRAIN_RD: state_d = ST_DRAIN_HOLD;
      ST_DRAIN_HOLD: begin
        if (out_ready) begin
          dcnt_d  = dcnt_q + 1'b1;
          state_d = (dcnt_q == DCNT_W'(DIGEST_WORDS - 1)) ? ST_IDLE : ST_DRAIN_RD;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if (core_phase && !core_in_range) err_oob_d = 1'b1;
  end

  // The RAM output register doubles as the core read register; the hold
  // register keeps mem_read_data frozen once drain reads reuse the port.
  always_comb begin
    core_rd_d = core_phase;
    rd_oob_d  = core_phase && !core_in_range;
    rd_hold_d = mem_read_data;
    ram_re    = core_phase || (state_q == ST_DRAIN_RD);
    ram_raddr = (state_q == ST_DRAIN_RD) ? OUT_IDX[AW-1:0] + AW'(dcnt_q)
                                         : core_idx[AW-1:0];
    ram_we    = 1'b0;
    ram_waddr = core_idx[AW-1:0];
    ram_wdata = mem_write_data;
    if ((state_q == ST_LOAD) && in_valid) begin
      ram_we    = 1'b1;
      ram_waddr = MSG_IDX[AW-1:0] + AW'(lcnt_q);
      ram_wdata = in_data;
    end else if (core_phase && mem_we && core_in_range) begin
      ram_we    = 1'b1;
    end
  end

  always_comb begin
    busy          = (state_q != ST_IDLE);
    in_ready      = (state_q == ST_LOAD);
    sha_start     = (state_q == ST_START);
    out_valid     = (state_q == ST_DRAIN_HOLD);
    out_last      = (state_q == ST_DRAIN_HOLD) && (dcnt_q == DCNT_W'(DIGEST_WORDS - 1));
    out_data      = (state_q == ST_DRAIN_HOLD) ? ram_rdata : '0;
    mem_read_data = core_rd_q ? (rd_oob_q ? '0 : ram_rdata) : rd_hold_q;
    message_addr  = MSG_ADDR;
    output_addr   = OUT_ADDR;
    err_oob       = err_oob_q;
    err_timeout   = err_timeout_q;
  end

  sha_word_ram #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_ram (
    .clk   (clk),
    .we    (ram_we),
    .waddr (ram_waddr),
    .wdata (ram_wdata),
    .re    (ram_re),
    .raddr (ram_raddr),
    .rdata (ram_rdata)
  );

endmodule

// File: tb/tb_sha_mem_responder.sv
// Self-checking bench for sha_mem_responder: a job-level reference model is
// compared on every negative edge, plus literal checks of each scenario.
module tb_sha_mem_responder;

   localparam int P_IDLE  = 0;
   localparam int P_LOAD  = 1;
   localparam int P_START = 2;
   localparam int P_WBUSY = 3;
   localparam int P_WDONE = 4;
   localparam int P_DRD   = 5;
   localparam int P_DHOLD = 6;
   localparam int NWORDS  = 20;
   localparam int OUTIDX  = 32;
   localparam int TMO     = 4096;

   logic        clk = 1'b0;
   logic        reset, cmd_go, in_valid, out_ready, sha_done, mem_we;
   logic [31:0] in_data, mem_write_data;
   logic [15:0] mem_addr;
   logic        busy, in_ready, out_valid, out_last, sha_start, err_oob, err_timeout;
   logic [31:0] out_data, mem_read_data;
   logic [15:0] message_addr, output_addr;

   int checks = 0;
   int passes = 0;

   logic [31:0] dig_words [8];
   logic [31:0] got_words [8];
   bit          got_last  [8];
   int          got_n;

   // Reference model state: job phase, counters, error flags, array image
   int          m_ph = P_IDLE;
   int          m_lc, m_dc, m_tc;
   bit          m_eoob, m_eto;
   logic [31:0] m_mem [64];
   bit          m_val [64];
   logic [31:0] m_rd;
   bit          m_rd_known = 1'b0;

   always #5 clk = ~clk;

   sha_mem_responder dut (
      .clk            (clk),
      .reset          (reset),
      .cmd_go         (cmd_go),
      .busy           (busy),
      .in_valid       (in_valid),
      .in_ready       (in_ready),
      .in_data        (in_data),
      .out_valid      (out_valid),
      .out_ready      (out_ready),
      .out_data       (out_data),
      .out_last       (out_last),
      .sha_start      (sha_start),
      .sha_done       (sha_done),
      .message_addr   (message_addr),
      .output_addr    (output_addr),
      .mem_addr       (mem_addr),
      .mem_we         (mem_we),
      .mem_write_data (mem_write_data),
      .mem_read_data  (mem_read_data),
      .err_oob        (err_oob),
      .err_timeout    (err_timeout)
   );

   task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act === exp) passes++;
      else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
   endtask

   task automatic applyStimulus();
      @(posedge clk);
      @(negedge clk);
   endtask

   // Model advances on the same edge as the DUT, from sampled inputs only
   always @(posedge clk) begin
      int idx;
      if (reset) begin
         m_ph <= P_IDLE; m_lc <= 0; m_dc <= 0; m_tc <= 0;
         m_eoob <= 1'b0; m_eto <= 1'b0; m_rd <= '0; m_rd_known <= 1'b1;
      end else begin
         idx = int'(16'(mem_addr - 16'h0000));
         if (m_ph == P_WBUSY || m_ph == P_WDONE) begin
            if (idx < 64) begin
               m_rd <= m_mem[idx];
               m_rd_known <= m_val[idx];
               if (mem_we) begin
                  m_mem[idx] <= mem_write_data;
                  m_val[idx] <= 1'b1;
               end
            end else begin
               m_rd <= '0;
               m_rd_known <= 1'b1;
               m_eoob <= 1'b1;
            end
         end
         case (m_ph)
            P_IDLE: if (cmd_go) begin
               m_eoob <= 1'b0; m_eto <= 1'b0; m_lc <= 0; m_ph <= P_LOAD;
            end
            P_LOAD: if (in_valid) begin
               m_mem[m_lc] <= in_data;
               m_val[m_lc] <= 1'b1;
               m_lc <= m_lc + 1;
               if (m_lc + 1 == NWORDS) m_ph <= P_START;
            end
            P_START: m_ph <= P_WBUSY;
            P_WBUSY: if (!sha_done) begin m_tc <= 0; m_ph <= P_WDONE; end
            P_WDONE: begin
               if (sha_done) begin
                  m_dc <= 0; m_ph <= P_DRD;
               end else if (m_tc + 1 >= TMO) begin
                  m_eto <= 1'b1; m_ph <= P_IDLE;
               end else m_tc <= m_tc + 1;
            end
            P_DRD: m_ph <= P_DHOLD;
            P_DHOLD: if (out_ready) begin
               m_dc <= m_dc + 1;
               m_ph <= (m_dc + 1 == 8) ? P_IDLE : P_DRD;
            end
            default: m_ph <= P_IDLE;
         endcase
      end
   end

   always @(negedge clk) begin
      checkOutput("ctrl{busy,in_ready,sha_start,out_valid,out_last,err_oob,err_timeout}",
                  {busy, in_ready, sha_start, out_valid, out_last, err_oob, err_timeout},
                  {m_ph != P_IDLE, m_ph == P_LOAD, m_ph == P_START, m_ph == P_DHOLD,
                   (m_ph == P_DHOLD) && (m_dc == 7), m_eoob, m_eto});
      if (m_ph == P_DHOLD && m_val[OUTIDX + m_dc])
         checkOutput("out_data", out_data, m_mem[OUTIDX + m_dc]);
      if (m_rd_known)
         checkOutput("mem_read_data", mem_read_data, m_rd);
   end

   initial begin
      #600000;
      $display("[TB] FAIL watchdog: time limit reached, got running, expected finished");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic runLoad(input bit seq, output int acc, output int starts);
      bit rdy;
      cmd_go = 1'b1;
      applyStimulus();
      cmd_go = 1'b0;
      acc = 0;
      starts = 0;
      for (int cyc = 0; cyc < 300; cyc++) begin
         in_valid = seq ? 1'b1 : ($urandom_range(0, 3) != 0);
         in_data  = seq ? 32'(acc) : $urandom;
         rdy = in_ready;
         applyStimulus();
         if (rdy && in_valid) acc++;
         if (sha_start) begin
            starts++;
            break;
         end
      end
      for (int k = 0; k < 2; k++) begin
         rdy = in_ready;
         applyStimulus();
         if (rdy && in_valid) acc++;
         if (sha_start) starts++;
      end
      in_valid = 1'b0;
   endtask

   task automatic writeDigest();
      sha_done = 1'b0;
      mem_we = 1'b0;
      mem_addr = 16'h0000;
      applyStimulus();
      for (int k = 0; k < 8; k++) begin
         mem_addr = 16'h0020 + 16'(k);
         mem_we = 1'b1;
         mem_write_data = dig_words[k];
         applyStimulus();
      end
      mem_we = 1'b0;
      mem_addr = 16'h0000;
      sha_done = 1'b1;
      applyStimulus();
   endtask

   task automatic runDrain(input bit toggle);
      bit rv, ol;
      logic [31:0] od;
      got_n = 0;
      for (int cyc = 0; cyc < 200; cyc++) begin
         out_ready = toggle ? (cyc % 2 == 0) : 1'($urandom_range(0, 1));
         rv = out_valid;
         od = out_data;
         ol = out_last;
         applyStimulus();
         if (rv && out_ready) begin
            if (got_n < 8) begin
               got_words[got_n] = od;
               got_last[got_n] = ol;
            end
            got_n++;
         end
         if (!busy) break;
      end
      out_ready = 1'b0;
   endtask

   initial begin
      int acc, starts, n;
      bit seen_out;
      reset = 1'b1; cmd_go = 1'b0; in_valid = 1'b0; in_data = '0;
      out_ready = 1'b0; sha_done = 1'b1; mem_addr = '0; mem_we = 1'b0; mem_write_data = '0;
      repeat (3) applyStimulus();
      reset = 1'b0;
      applyStimulus();
      checkOutput("reset_busy", busy, 0);
      checkOutput("reset_out_data", out_data, 0);
      checkOutput("reset_mem_read_data", mem_read_data, 0);
      checkOutput("reset_err_flags", {err_oob, err_timeout}, 0);
      checkOutput("message_addr", message_addr, 16'h0000);
      checkOutput("output_addr", output_addr, 16'h0020);

      // Load 0..19 with in_valid held, then read the words back over the bus
      runLoad(1'b1, acc, starts);
      checkOutput("load_accepts", acc, 20);
      checkOutput("start_pulses", starts, 1);
      for (int i = 0; i < 20; i++) begin
         mem_addr = 16'(i);
         applyStimulus();
         checkOutput($sformatf("array_word_%0d", i), mem_read_data, 32'(i));
      end
      mem_addr = 16'h0020; mem_we = 1'b1; mem_write_data = 32'hA5A5A5A5;
      applyStimulus();
      mem_we = 1'b0;
      applyStimulus();
      checkOutput("core_write_readback", mem_read_data, 32'hA5A5A5A5);

      // Out-of-range read and write
      mem_addr = 16'h0050;
      applyStimulus();
      checkOutput("oob_read_data", mem_read_data, 0);
      checkOutput("oob_flag", err_oob, 1);
      mem_we = 1'b1; mem_write_data = 32'hDEADBEEF;
      applyStimulus();
      mem_we = 1'b0; mem_addr = 16'h0010;
      applyStimulus();
      checkOutput("oob_write_dropped", mem_read_data, 32'h10);
      checkOutput("oob_flag_sticky", err_oob, 1);

      // Full job: digest 0x11111111..0x88888888, out_ready toggling
      for (int k = 0; k < 8; k++) dig_words[k] = 32'(32'h11111111 * (k + 1));
      writeDigest();
      runDrain(1'b1);
      checkOutput("drain_count", got_n, 8);
      for (int k = 0; k < 8; k++) begin
         checkOutput($sformatf("drain_word_%0d", k), got_words[k], 32'(32'h11111111 * (k + 1)));
         checkOutput($sformatf("drain_last_%0d", k), got_last[k], k == 7);
      end
      checkOutput("drain_idle", busy, 0);

      // Core never drops done: stuck in WAIT_BUSY until reset
      runLoad(1'b0, acc, starts);
      repeat (50) applyStimulus();
      checkOutput("stuck_busy", busy, 1);
      reset = 1'b1;
      applyStimulus();
      reset = 1'b0;
      checkOutput("stuck_reset_idle", busy, 0);

      // Core drops done and never raises it: timeout
      runLoad(1'b0, acc, starts);
      checkOutput("timeout_job_accepts", acc, 20);
      sha_done = 1'b0;
      n = 0;
      seen_out = 1'b0;
      for (int cyc = 0; cyc < 5000; cyc++) begin
         applyStimulus();
         n++;
         if (out_valid) seen_out = 1'b1;
         if (!busy) break;
      end
      checkOutput("timeout_cycles", n, 4097);
      checkOutput("timeout_flag", err_timeout, 1);
      checkOutput("timeout_no_output", seen_out, 0);
      sha_done = 1'b1;
      applyStimulus();

      // Reset during DRAIN_HOLD
      runLoad(1'b0, acc, starts);
      for (int k = 0; k < 8; k++) dig_words[k] = $urandom;
      writeDigest();
      for (int cyc = 0; cyc < 10 && !out_valid; cyc++) applyStimulus();
      checkOutput("hold_reached", out_valid, 1);
      reset = 1'b1;
      applyStimulus();
      reset = 1'b0;
      checkOutput("midjob_reset_out_valid", out_valid, 0);
      checkOutput("midjob_reset_busy", busy, 0);
      mem_addr = 16'h0021;
      runLoad(1'b0, acc, starts);
      applyStimulus();
      checkOutput("array_retained", mem_read_data, dig_words[1]);
      mem_addr = 16'h0000;
      for (int k = 0; k < 8; k++) dig_words[k] = $urandom;
      writeDigest();
      runDrain(1'b0);
      checkOutput("rerun_count", got_n, 8);
      for (int k = 0; k < 8; k++)
         checkOutput($sformatf("rerun_word_%0d", k), got_words[k], dig_words[k]);
      checkOutput("rerun_idle", busy, 0);
      checkOutput("rerun_err_flags", {err_oob, err_timeout}, 0);

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
